player_physics: RTL and testbench

Per-frame player motion engine for the platformer core. It is the parametrised successor of the single-sprite ball mover. Once per frame tick it applies directional input, jump impulse, gravity and terminal velocity. It then resolves motion pixel by pixel against the shared tile map through a synchronous read port, and publishes a stable top-left position and grounded flag to the sprite renderer.

---
 rtl/phys_pkg.sv | 20 ++
 rtl/tile_probe.sv | 23 ++
 rtl/player_physics.sv | 231 +++++++++++++++++++++++
 tb/tb_player_physics.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/phys_pkg.sv
// Shared types and constants for the player motion engine.
package phys_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_VEL,
        S_XP1, S_XP2, S_XCHK,
        S_YP1, S_YP2, S_YCHK,
        S_GP1, S_GP2, S_GCHK,
        S_DONE
    } phys_state_t;

    typedef logic [2:0] tile_code_t;

    localparam tile_code_t SOLID = 3'b111;

    typedef enum logic [1:0] {
        DIR_RIGHT, DIR_LEFT, DIR_DOWN, DIR_UP
    } probe_dir_t;

endpackage

// File: rtl/tile_probe.sv
// Maps a probe pixel to its tile address and flags pixels outside the map,
// which the caller treats as solid regardless of tile memory.
module tile_probe #(
    parameter int TILE_LOG2 = 5,
    parameter int MAP_W     = 20,
    parameter int MAP_H     = 15
) (
    input  logic [9:0] i_px,
    input  logic [9:0] i_py,
    output logic [3:0] o_row,
    output logic [4:0] o_col,
    output logic       o_oob
);

    // One extra bit so a map that spans the whole 10-bit space never flags.
    localparam logic [10:0] LIM_X = 11'(MAP_W << TILE_LOG2);
    localparam logic [10:0] LIM_Y = 11'(MAP_H << TILE_LOG2);

    assign o_row = 4'(i_py >> TILE_LOG2);
    assign o_col = 5'(i_px >> TILE_LOG2);
    assign o_oob = ({1'b0, i_px} >= LIM_X) | ({1'b0, i_py} >= LIM_Y);

endmodule

// File: rtl/player_physics.sv
// Per-frame player motion: velocity update, pixel-stepped X/Y collision
// against the tile map, ground check, then atomic publish of the results.
//
// state | meaning
// IDLE  | waiting for frame_tick
// VEL   | derive vx, update vy, load step counters
// XP1   | present leading-column corner A address
// XP2   | capture A, present corner B address
// XCHK  | evaluate B, step x or abort
// YP1/YP2/YCHK | same scheme for the leading row
// GP1/GP2/GCHK | probe row below the hitbox for on_ground
// DONE  | publish working state, pulse done
module player_physics #(
    parameter int TILE_LOG2 = 5,
    parameter int MAP_W     = 20,
    parameter int MAP_H     = 15,
    parameter int SIZE_X    = 16,
    parameter int SIZE_Y    = 24,
    parameter int X_SPEED   = 2,
    parameter int GRAVITY   = 1,
    parameter int V_TERM    = 10,
    parameter int JUMP_V    = 10,
    parameter int SPAWN_X   = 308,
    parameter int SPAWN_Y   = 40
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       move_left,
    input  logic       move_right,
    input  logic       jump_req,
    output logic [3:0] tile_row,
    output logic [4:0] tile_col,
    input  logic [2:0] tile_data,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic [9:0] vel_y,
    output logic       on_ground,
    output logic       busy,
    output logic       done,
    output logic       overrun
);
    import phys_pkg::*;

    localparam logic [9:0] C_SX    = 10'(SIZE_X);
    localparam logic [9:0] C_SY    = 10'(SIZE_Y);
    localparam logic [9:0] C_XSPD  = 10'(X_SPEED);
    localparam logic [9:0] C_GRAV  = 10'(GRAVITY);
    localparam logic [9:0] C_VTERM = 10'(V_TERM);
    localparam logic [9:0] C_JUMP  = 10'(JUMP_V);

    phys_state_t r_state, w_next;

    logic [9:0]        r_x, r_y;
    logic signed [9:0] r_vy;
    logic [9:0]        r_xsteps, r_ysteps;
    logic              r_xneg, r_gnd;
    logic              r_oob_a, r_solid_a;

    logic [9:0]        r_pos_x, r_pos_y;
    logic signed [9:0] r_vel_y;
    logic              r_on_ground, r_done, r_overrun;

    logic              w_go_left, w_go_right;
    logic signed [9:0] w_vy_fall, w_vy_vel;
    logic [9:0]        w_vy_mag, w_xsteps_vel;

    probe_dir_t        w_dir;
    logic              w_corner_b, w_probing;
    logic [9:0]        w_px, w_py;
    logic [3:0]        w_row;
    logic [4:0]        w_col;
    logic              w_oob, w_hit;

    assign w_go_right = move_right & ~move_left;
    assign w_go_left  = move_left & ~move_right;

    always_comb begin
        w_vy_fall = r_vy + $signed(C_GRAV);
        if (w_vy_fall > $signed(C_VTERM))
            w_vy_fall = $signed(C_VTERM);
        if (r_on_ground)
            w_vy_vel = jump_req ? -$signed(C_JUMP) : 10'sd0;
        else
            w_vy_vel = w_vy_fall;
        w_vy_mag     = w_vy_vel[9] ? $unsigned(-w_vy_vel) : $unsigned(w_vy_vel);
        w_xsteps_vel = (w_go_right | w_go_left) ? C_XSPD : 10'd0;
    end

    // Corner A is the first probe of a step, corner B the second; B stays
    // selected through CHK so its out-of-map flag is still valid there.
    always_comb begin
        w_dir      = DIR_DOWN;
        w_corner_b = 1'b0;
        w_probing  = 1'b0;
        case (r_state)
            S_XP1:         begin w_dir = r_xneg ? DIR_LEFT : DIR_RIGHT; w_probing = 1'b1; end
            S_XP2:         begin w_dir = r_xneg ? DIR_LEFT : DIR_RIGHT; w_corner_b = 1'b1; w_probing = 1'b1; end
            S_XCHK:        begin w_dir = r_xneg ? DIR_LEFT : DIR_RIGHT; w_corner_b = 1'b1; end
            S_YP1:         begin w_dir = r_vy[9] ? DIR_UP : DIR_DOWN; w_probing = 1'b1; end
            S_YP2:         begin w_dir = r_vy[9] ? DIR_UP : DIR_DOWN; w_corner_b = 1'b1; w_probing = 1'b1; end
            S_YCHK:        begin w_dir = r_vy[9] ? DIR_UP : DIR_DOWN; w_corner_b = 1'b1; end
            S_GP1:         w_probing = 1'b1;
            S_GP2:         begin w_corner_b = 1'b1; w_probing = 1'b1; end
            S_GCHK:        w_corner_b = 1'b1;
            default:       ;
        endcase

        w_px = r_x;
        w_py = r_y;
        case (w_dir)
            DIR_RIGHT: begin w_px = r_x + C_SX;  w_py = w_corner_b ? r_y + C_SY - 10'd1 : r_y; end
            DIR_LEFT:  begin w_px = r_x - 10'd1; w_py = w_corner_b ? r_y + C_SY - 10'd1 : r_y; end
            DIR_DOWN:  begin w_py = r_y + C_SY;  w_px = w_corner_b ? r_x + C_SX - 10'd1 : r_x; end
            DIR_UP:    begin w_py = r_y - 10'd1; w_px = w_corner_b ? r_x + C_SX - 10'd1 : r_x; end
            default:   ;
        endcase
    end

    tile_probe #(
        .TILE_LOG2 (TILE_LOG2),
        .MAP_W     (MAP_W),
        .MAP_H     (MAP_H)
    ) u_probe (
        .i_px  (w_px),
        .i_py  (w_py),
        .o_row (w_row),
        .o_col (w_col),
        .o_oob (w_oob)
    );

    assign tile_row = w_probing ? w_row : 4'd0;
    assign tile_col = w_probing ? w_col : 5'd0;
    assign w_hit    = r_solid_a | w_oob | (tile_data == SOLID);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (frame_tick) w_next = S_VEL;
            S_VEL: begin
                if (w_xsteps_vel != 10'd0)  w_next = S_XP1;
                else if (w_vy_mag != 10'd0) w_next = S_YP1;
                else                        w_next = S_GP1;
            end
            S_XP1:  w_next = S_XP2;
            S_XP2:  w_next = S_XCHK;
            S_XCHK: begin
                if (!w_hit && r_xsteps != 10'd1) w_next = S_XP1;
                else if (r_ysteps != 10'd0)      w_next = S_YP1;
                else                             w_next = S_GP1;
            end
            S_YP1:  w_next = S_YP2;
            S_YP2:  w_next = S_YCHK;
            S_YCHK: w_next = (!w_hit && r_ysteps != 10'd1) ? S_YP1 : S_GP1;
            S_GP1:  w_next = S_GP2;
            S_GP2:  w_next = S_GCHK;
            S_GCHK: w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_x         <= 10'(SPAWN_X);
            r_y         <= 10'(SPAWN_Y);
            r_vy        <= '0;
            r_xsteps    <= '0;
            r_ysteps    <= '0;
            r_xneg      <= 1'b0;
            r_gnd       <= 1'b0;
            r_oob_a     <= 1'b0;
            r_solid_a   <= 1'b0;
            r_pos_x     <= 10'(SPAWN_X);
            r_pos_y     <= 10'(SPAWN_Y);
            r_vel_y     <= '0;
            r_on_ground <= 1'b0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (frame_tick && r_state != S_IDLE)
                r_overrun <= 1'b1;
            case (r_state)
                S_VEL: begin
                    r_vy     <= w_vy_vel;
                    r_xsteps <= w_xsteps_vel;
                    r_ysteps <= w_vy_mag;
                    r_xneg   <= w_go_left;
                end
                S_XP1, S_YP1, S_GP1: r_oob_a <= w_oob;
                S_XP2, S_YP2, S_GP2: r_solid_a <= r_oob_a | (tile_data == SOLID);
                S_XCHK: if (!w_hit) begin
                    r_x      <= r_xneg ? r_x - 10'd1 : r_x + 10'd1;
                    r_xsteps <= r_xsteps - 10'd1;
                end
                S_YCHK: begin
                    if (w_hit) begin
                        r_vy <= '0;
                    end else begin
                        r_y      <= r_vy[9] ? r_y - 10'd1 : r_y + 10'd1;
                        r_ysteps <= r_ysteps - 10'd1;
                    end
                end
                S_GCHK: r_gnd <= w_hit;
                S_DONE: begin
                    r_pos_x     <= r_x;
                    r_pos_y     <= r_y;
                    r_vel_y     <= r_vy;
                    r_on_ground <= r_gnd;
                    r_done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign pos_x     = r_pos_x;
    assign pos_y     = r_pos_y;
    assign vel_y     = r_vel_y;
    assign on_ground = r_on_ground;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_player_physics.sv
// Scoreboard bench: a frame-level reference model predicts each published
// result; a monitor compares on every done pulse.
module tb_player_physics;

    localparam int SX = 16, SY = 24, SPAWN_X = 308, SPAWN_Y = 40;
    localparam int PIX_W = 640, PIX_H = 480;

    logic       Clk = 1'b0, Reset = 1'b0, frame_tick = 1'b0;
    logic       move_left = 1'b0, move_right = 1'b0, jump_req = 1'b0;
    logic [3:0] tile_row;
    logic [4:0] tile_col;
    logic [2:0] tile_data = 3'd0;
    logic [9:0] pos_x, pos_y, vel_y;
    logic       on_ground, busy, done, overrun;

    int     checks = 0, errors = 0, n_done = 0;
    longint cyc = 0;

    typedef struct {
        int x; int y; int vy; int g; int lat; longint tcyc;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    int m_x, m_y, m_vy, m_gnd;

    player_physics dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
        .move_left(move_left), .move_right(move_right), .jump_req(jump_req),
        .tile_row(tile_row), .tile_col(tile_col), .tile_data(tile_data),
        .pos_x(pos_x), .pos_y(pos_y), .vel_y(vel_y), .on_ground(on_ground),
        .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // Rows >= 11 solid, row 10 cols 16..19 solid; free tiles use codes 0..6.
    function automatic logic [2:0] map_code(input int r, input int c);
        if (r >= 11 || (r == 10 && c >= 16 && c <= 19)) return 3'b111;
        return 3'((r + c) % 7);
    endfunction

    always @(posedge Clk) tile_data <= map_code(int'(tile_row), int'(tile_col));

    function automatic bit m_solid(input int px, input int py);
        px = px & 1023;
        py = py & 1023;
        if (px >= PIX_W || py >= PIX_H) return 1'b1;
        return map_code(py / 32, px / 32) == 3'b111;
    endfunction

    task automatic model_reset();
        m_x = SPAWN_X; m_y = SPAWN_Y; m_vy = 0; m_gnd = 0;
    endtask

    task automatic model_frame(input bit l, input bit r, input bit j, output exp_t e);
        int vx, n, dir, probes, px, py;
        vx = (r && !l) ? 2 : ((l && !r) ? -2 : 0);
        if (m_gnd != 0 && j)  m_vy = -10;
        else if (m_gnd != 0)  m_vy = 0;
        else                  m_vy = (m_vy + 1 > 10) ? 10 : m_vy + 1;
        probes = 0;
        n   = vx < 0 ? -vx : vx;
        dir = vx < 0 ? -1 : 1;
        for (int i = 0; i < n; i++) begin
            probes++;
            px = vx > 0 ? m_x + SX : m_x - 1;
            if (m_solid(px, m_y) || m_solid(px, m_y + SY - 1)) break;
            m_x = (m_x + dir) & 1023;
        end
        n   = m_vy < 0 ? -m_vy : m_vy;
        dir = m_vy < 0 ? -1 : 1;
        for (int i = 0; i < n; i++) begin
            probes++;
            py = dir > 0 ? m_y + SY : m_y - 1;
            if (m_solid(m_x, py) || m_solid(m_x + SX - 1, py)) begin
                m_vy = 0;
                break;
            end
            m_y = (m_y + dir) & 1023;
        end
        m_gnd = (m_solid(m_x, m_y + SY) || m_solid(m_x + SX - 1, m_y + SY)) ? 1 : 0;
        e.x = m_x; e.y = m_y; e.vy = m_vy; e.g = m_gnd;
        e.lat = 3 * (probes + 1) + 2;
        e.tcyc = 0;
    endtask

    task automatic check(input string name, input logic signed [31:0] got,
                         input logic signed [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask

    always @(negedge Clk) begin
        if (!Reset && done) begin
            n_done++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done got done=1 expected no pending frame");
            end else begin
                mon_e = sb.pop_front();
                check("pos_x", pos_x, mon_e.x);
                check("pos_y", pos_y, mon_e.y);
                check("vel_y", $signed(vel_y), mon_e.vy);
                check("on_ground", on_ground, mon_e.g);
                check("busy_at_done", busy, 0);
                check("latency", int'(cyc - mon_e.tcyc), mon_e.lat);
            end
        end
    end

    task automatic issue_tick(input bit l, input bit r, input bit j);
        exp_t e;
        move_left = l; move_right = r; jump_req = j;
        frame_tick = 1'b1;
        model_frame(l, r, j, e);
        e.tcyc = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic frame(input bit l, input bit r, input bit j);
        int n0;
        n0 = n_done;
        @(negedge Clk);
        issue_tick(l, r, j);
        @(negedge Clk);
        frame_tick = 1'b0;
        for (int i = 0; i < 100 && n_done == n0; i++) @(negedge Clk);
        check("done_seen", n_done - n0, 1);
    endtask

    initial begin
        int n0;
        #900000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        model_reset();
        #2 Reset = 1'b1;
        repeat (3) @(negedge Clk);
        check("rst_pos_x", pos_x, SPAWN_X);
        check("rst_pos_y", pos_y, SPAWN_Y);
        check("rst_vel_y", vel_y, 0);
        check("rst_on_ground", on_ground, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_tile_row", tile_row, 0);
        check("rst_tile_col", tile_col, 0);
        Reset = 1'b0;

        // free fall from spawn until landing on row 11
        repeat (40) frame(0, 0, 0);
        check("land_pos_y", pos_y, 328);
        check("land_on_ground", on_ground, 1);
        check("land_vel_y", $signed(vel_y), 0);

        frame(0, 0, 1);
        check("jump_pos_y", pos_y, 318);
        check("jump_vel_y", $signed(vel_y), -10);
        check("jump_on_ground", on_ground, 0);
        frame(0, 0, 0);
        check("jump2_vel_y", $signed(vel_y), -9);
        repeat (30) frame(0, 0, 0);
        check("reland_on_ground", on_ground, 1);

        // right edge 511 ends up flush against solid column 16
        repeat (100) frame(0, 1, 0);
        check("right_stop_x", pos_x, 496);
        repeat (255) frame(1, 0, 0);
        check("left_stop_x", pos_x, 0);

        repeat (150) frame($urandom_range(0, 1), $urandom_range(0, 1),
                           $urandom_range(0, 3) == 0);

        check("overrun_pre", overrun, 0);
        n0 = n_done;
        @(negedge Clk);
        issue_tick(0, 0, 0);
        @(negedge Clk);
        frame_tick = 1'b0;
        @(negedge Clk);
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        check("overrun_set", overrun, 1);
        for (int i = 0; i < 100 && n_done == n0; i++) @(negedge Clk);
        repeat (30) @(negedge Clk);
        check("overrun_done_count", n_done - n0, 1);
        repeat (3) frame(0, 0, 0);
        check("overrun_sticky", overrun, 1);

        // fresh reset, then abort a frame while it is resolving Y
        @(negedge Clk);
        Reset = 1'b1;
        sb.delete();
        model_reset();
        @(negedge Clk);
        Reset = 1'b0;
        check("overrun_cleared", overrun, 0);
        @(negedge Clk);
        move_left = 1'b0; move_right = 1'b0; jump_req = 1'b0;
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        check("busy_mid", busy, 1);
        Reset = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_pos_x", pos_x, SPAWN_X);
        check("midrst_pos_y", pos_y, SPAWN_Y);
        check("midrst_vel_y", vel_y, 0);
        check("midrst_done", done, 0);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (5) frame(0, 0, 0);

        repeat (5) @(negedge Clk);
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
